nonce_result_scan: RTL and testbench

- Downstream consumer of bitcoin_hash.
- After bitcoin_hash writes NUM_NONCES final H0 words to memory at output_addr, this block reads them back through the same single-port memory interface.
- Compares each word against a difficulty target, tracks the first qualifying nonce and the minimum hash, then writes a two-word summary to memory.
- Result is presented to the mining controller on output ports.

---
 rtl/nonce_result_scan_if.sv | 25 ++
 rtl/nonce_result_scan.sv | 118 +++++++++++
 tb/tb_nonce_result_scan.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nonce_result_scan_if.sv
// Single-port memory bus shared by the hash core and the result scanner.
// master drives address/write side; slave (memory) returns registered read data.
interface nonce_result_scan_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES H0 words for first hit below target and the minimum hash, then writes a 2-word summary.
// Latency 3*NUM_NONCES+2 edges from start to done; no backpressure, start is ignored while busy.
module nonce_result_scan #(
    parameter int NUM_NONCES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          result_addr,
    input  logic [15:0]          summary_addr,
    input  logic [31:0]          target,
    output logic                 done,
    output logic                 found,
    output logic [7:0]           found_nonce,
    output logic [31:0]          min_hash,
    output logic [7:0]           min_nonce,
    nonce_result_scan_if.master  mem
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR_FOUND, WR_MIN, DONE
    } state_t;

    state_t      state;
    logic [7:0]  idx;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdat_q;

    logic        found_nxt;
    logic [7:0]  found_nonce_nxt;
    logic [31:0] min_hash_nxt;
    logic [7:0]  min_nonce_nxt;

    assign mem.mem_clk        = clk;
    assign mem.mem_we         = we_q;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_write_data = wdat_q;

    // Result registers as they will stand after absorbing the word on mem_read_data.
    always_comb begin
        found_nxt       = found;
        found_nonce_nxt = found_nonce;
        min_hash_nxt    = min_hash;
        min_nonce_nxt   = min_nonce;
        if (!found && (mem.mem_read_data < target)) begin
            found_nxt       = 1'b1;
            found_nonce_nxt = idx;
        end
        if (mem.mem_read_data < min_hash) begin
            min_hash_nxt  = mem.mem_read_data;
            min_nonce_nxt = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 8'd0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= 8'hFF;
            min_hash    <= 32'hFFFF_FFFF;
            min_nonce   <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= 16'd0;
            wdat_q      <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        found       <= 1'b0;
                        found_nonce <= 8'hFF;
                        min_hash    <= 32'hFFFF_FFFF;
                        min_nonce   <= 8'd0;
                        idx         <= 8'd0;
                        addr_q      <= result_addr;
                        state       <= RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_WAIT;
                RD_WAIT: state <= RD_CAP;
                RD_CAP: begin
                    found       <= found_nxt;
                    found_nonce <= found_nonce_nxt;
                    min_hash    <= min_hash_nxt;
                    min_nonce   <= min_nonce_nxt;
                    if (idx == LAST_IDX) begin
                        we_q   <= 1'b1;
                        addr_q <= summary_addr;
                        wdat_q <= {found_nxt, 7'b0, min_nonce_nxt, 8'b0, found_nonce_nxt};
                        state  <= WR_FOUND;
                    end else begin
                        idx    <= idx + 8'd1;
                        addr_q <= result_addr + {8'd0, idx} + 16'd1;
                        state  <= RD_ADDR;
                    end
                end
                WR_FOUND: begin
                    we_q   <= 1'b1;
                    addr_q <= summary_addr + 16'd1;
                    wdat_q <= min_hash;
                    state  <= WR_MIN;
                end
                WR_MIN: begin
                    we_q  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_scan.sv
// Directed bench for nonce_result_scan with a registered-read memory model and a result scoreboard.
module tb_nonce_result_scan;

    typedef struct packed {
        logic        f;
        logic [7:0]  fn;
        logic [31:0] mh;
        logic [7:0]  mn;
        logic [31:0] s0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] result_addr;
    logic [15:0] summary_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [7:0]  found_nonce;
    logic [31:0] min_hash;
    logic [7:0]  min_nonce;

    logic        pl_we;
    logic [15:0] pl_addr;
    logic [31:0] pl_dat;
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    logic [15:0] cur_sa;
    int          we_cnt = 0;
    int          bad_we = 0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    nonce_result_scan_if bus();

    nonce_result_scan #(.NUM_NONCES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .result_addr  (result_addr),
        .summary_addr (summary_addr),
        .target       (target),
        .done         (done),
        .found        (found),
        .found_nonce  (found_nonce),
        .min_hash     (min_hash),
        .min_nonce    (min_nonce),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge bus.mem_clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
        else if (pl_we) mem[pl_addr] <= pl_dat;
        rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_read_data = rd_q;

    always @(posedge clk) begin
        if (!reset && bus.mem_we) begin
            we_cnt <= we_cnt + 1;
            if (bus.mem_addr != cur_sa && bus.mem_addr != 16'(cur_sa + 16'd1))
                bad_we <= bad_we + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_we   = 1'b1;
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    function automatic exp_t model(input logic [15:0] ra, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] h;
        e = '{1'b0, 8'hFF, 32'hFFFF_FFFF, 8'h00, 32'h0};
        for (int n = 0; n < 16; n++) begin
            h = mem[16'(ra + 16'(n))];
            if (!e.f && h < tgt) begin
                e.f  = 1'b1;
                e.fn = 8'(n);
            end
            if (h < e.mh) begin
                e.mh = h;
                e.mn = 8'(n);
            end
        end
        e.s0 = {e.f, 7'b0, e.mn, 8'b0, e.fn};
        return e;
    endfunction

    // Pulse start, count edges until done, then compare against the oldest scoreboard entry.
    task automatic scan(input string tag, input logic [15:0] ra, input logic [15:0] sa,
                        input logic [31:0] tgt, input exp_t e, input int pulse_at);
        int   n;
        int   we0;
        exp_t g;
        result_addr  = ra;
        summary_addr = sa;
        target       = tgt;
        cur_sa       = sa;
        sb.push_back(e);
        we0 = we_cnt;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 300) begin
            if (n == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd50);
        g = sb.pop_front();
        chk({tag, "_found"},       32'(found),       32'(g.f));
        chk({tag, "_found_nonce"}, 32'(found_nonce), 32'(g.fn));
        chk({tag, "_min_hash"},    min_hash,         g.mh);
        chk({tag, "_min_nonce"},   32'(min_nonce),   32'(g.mn));
        chk({tag, "_mem_sum0"},    mem[sa],          g.s0);
        chk({tag, "_mem_sum1"},    mem[16'(sa + 16'd1)], g.mh);
        chk({tag, "_we_cycles"},   32'(we_cnt - we0), 32'd2);
        chk({tag, "_bad_we"},      32'(bad_we),      32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] w;
        exp_t        e;
        reset = 1'b1; start = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        result_addr = '0; summary_addr = '0; target = '0; cur_sa = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_found",       32'(found),       32'd0);
        chk("rst_found_nonce", 32'(found_nonce), 32'h0000_00FF);
        chk("rst_min_hash",    min_hash,         32'hFFFF_FFFF);
        chk("rst_min_nonce",   32'(min_nonce),   32'd0);
        chk("rst_mem_we",      32'(bus.mem_we),  32'd0);
        chk("rst_mem_addr",    32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdat",    bus.mem_write_data, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Ascending words: first word is both first hit and minimum.
        for (int i = 0; i < 16; i++) load(16'(1000 + i), 32'h1000_0000 + 32'(i));
        scan("asc", 16'd1000, 16'd2000, 32'h1000_0005,
             '{1'b1, 8'h00, 32'h1000_0000, 8'h00, 32'h8000_0000}, -1);

        // Descending words, target too small to hit.
        for (int i = 0; i < 16; i++) load(16'(1000 + i), 32'hF000_0000 - 32'(i));
        scan("desc", 16'd1000, 16'd2000, 32'h0000_0001,
             '{1'b0, 8'hFF, 32'hEFFF_FFF1, 8'h0F, 32'h000F_00FF}, -1);

        // Tie at 7 and 9; a stray start pulse mid-scan must be ignored.
        for (int i = 0; i < 16; i++)
            load(16'(1000 + i), (i == 7 || i == 9) ? 32'h0000_0010 : 32'h5555_5555);
        scan("tie", 16'd1000, 16'd2000, 32'h0000_0020,
             '{1'b1, 8'h07, 32'h0000_0010, 8'h07, 32'h8007_0007}, 20);

        // Restart straight from DONE; target equal to the minimum is not a hit.
        scan("strict", 16'd1000, 16'd2000, 32'h0000_0010,
             '{1'b0, 8'hFF, 32'h0000_0010, 8'h07, 32'h0007_00FF}, -1);

        // Reset while word 8 is being read.
        @(negedge clk); start = 1'b1; target = 32'h0000_0020;
        @(posedge clk); #1; start = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_done",     32'(done),       32'd0);
        chk("mid_rst_mem_we",   32'(bus.mem_we), 32'd0);
        chk("mid_rst_found",    32'(found),      32'd0);
        chk("mid_rst_min_hash", min_hash,        32'hFFFF_FFFF);
        @(negedge clk); reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_addr != 16'd0 || bus.mem_we || done) n++;
        end
        chk("mid_rst_stays_idle", 32'(n), 32'd0);
        scan("after_rst", 16'd1000, 16'd2000, 32'h0000_0020,
             '{1'b1, 8'h07, 32'h0000_0010, 8'h07, 32'h8007_0007}, -1);

        // All-ones words with target 0: never found, minimum keeps index 0.
        for (int i = 0; i < 16; i++) load(16'(3000 + i), 32'hFFFF_FFFF);
        scan("ones_t0", 16'd3000, 16'd2000, 32'h0000_0000,
             '{1'b0, 8'hFF, 32'hFFFF_FFFF, 8'h00, 32'h0000_00FF}, -1);

        // Read and summary addresses both wrap through 0xFFFF.
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            load(16'(16'hFFF8 + 16'(i)), w);
        end
        w = mem[16'h0003];
        e = model(16'hFFF8, w);
        scan("wrap", 16'hFFF8, 16'hFFFF, w, e, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
